// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy-tree fan-in collector.
// Default widths match the generated trees: five children, byte payloads.
package hier_node_pkg;
   localparam int MSG_CNT_W   = 16;
   localparam int DEF_N_CHILD = 5;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_IDX_W   = $clog2(DEF_N_CHILD);

   typedef struct packed {
      logic [DEF_IDX_W-1:0]  idx;
      logic [DEF_DATA_W-1:0] data;
   } msg_t;

   function automatic logic [MSG_CNT_W-1:0] sat_inc(input logic [MSG_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/hier_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
// The pointer register itself lives in the parent.
module hier_rr_arbiter #(
   parameter  int N_CHILD = 5,
   localparam int IDX_W   = $clog2(N_CHILD)
) (
   input  logic [N_CHILD-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               en,
   output logic [N_CHILD-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any_gnt
);
   int               c;
   logic [IDX_W-1:0] cidx;

   // Walk offsets from far to near so the nearest requester is written last.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      c       = 0;
      cidx    = '0;
      for (int k = N_CHILD - 1; k >= 0; k--) begin
         c = int'(ptr) + k;
         if (c >= N_CHILD) c = c - N_CHILD;
         cidx = IDX_W'(c);
         if (en && req[cidx]) begin
            gnt       = '0;
            gnt[cidx] = 1'b1;
            gnt_idx   = cidx;
            any_gnt   = 1'b1;
         end
      end
   end
endmodule

// File: rtl/hier_node_collector.sv
// Return-path fan-in node: arbitrates child status messages, tags them with
// the child index and forwards them upstream through a small FIFO.
module hier_node_collector
   import hier_node_pkg::*;
#(
   parameter  int N_CHILD = 5,
   parameter  int DATA_W  = 8,
   parameter  int DEPTH   = 4,
   localparam int IDX_W   = $clog2(N_CHILD)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_CHILD-1:0]        child_valid,
   input  logic [N_CHILD*DATA_W-1:0] child_data,
   output logic [N_CHILD-1:0]        child_ready,
   output logic                      up_valid,
   output logic [DATA_W-1:0]         up_data,
   output logic [IDX_W-1:0]          up_idx,
   input  logic                      up_ready,
   output logic [MSG_CNT_W-1:0]      fwd_count,
   output logic                      busy
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic [DATA_W-1:0]    data_arr [N_CHILD];
   entry_t               mem_q    [DEPTH];
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [MSG_CNT_W-1:0] fwd_count_q, fwd_count_d;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 any_gnt, grant_en, push, pop;

   genvar gi;
   generate
      for (gi = 0; gi < N_CHILD; gi++) begin : g_unpack
         assign data_arr[gi] = child_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Grants depend on the registered count only, so a full FIFO refuses even
   // when it is popped in the same cycle; rst also holds child_ready low.
   assign grant_en = !rst && (count_q < CNT_W'(DEPTH));

   hier_rr_arbiter #(.N_CHILD(N_CHILD)) u_arb (
      .req     (child_valid),
      .ptr     (rr_ptr_q),
      .en      (grant_en),
      .gnt     (child_ready),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   assign push = any_gnt;
   assign pop  = up_valid && up_ready;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      fwd_count_d = fwd_count_q;
      if (push) begin
         rr_ptr_d = (gnt_idx == IDX_W'(N_CHILD - 1)) ? '0 : gnt_idx + 1'b1;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         fwd_count_d = sat_inc(fwd_count_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         fwd_count_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         fwd_count_q <= fwd_count_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{idx: gnt_idx, data: data_arr[gnt_idx]};
   end

   assign up_valid  = (count_q != '0);
   assign up_data   = mem_q[rd_ptr_q].data;
   assign up_idx    = mem_q[rd_ptr_q].idx;
   assign fwd_count = fwd_count_q;
   assign busy      = up_valid || (|child_valid);
endmodule

// File: tb/tb_hier_node_collector.sv
// Scoreboard bench for hier_node_collector: driver predicts grants from a
// queue-level model, a separate monitor checks every upstream pop.
module tb_hier_node_collector;
   localparam int N  = 5;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int IW = 3;

   typedef struct {
      int idx;
      int data;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   child_valid, child_ready;
   logic [N*W-1:0] child_data;
   logic           up_valid, up_ready, busy;
   logic [W-1:0]   up_data;
   logic [IW-1:0]  up_idx;
   logic [15:0]    fwd_count;

   int   tests = 0;
   int   fails = 0;
   int   m_count, m_rr, m_fwd, last_g;
   int   tally [N];
   bit   quiet = 1'b0;
   exp_t sbq [$];
   exp_t mon_e;
   logic [N-1:0]   cur_v;
   logic [N*W-1:0] cur_d;

   hier_node_collector #(.N_CHILD(N), .DATA_W(W), .DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .child_valid (child_valid),
      .child_data  (child_data),
      .child_ready (child_ready),
      .up_valid    (up_valid),
      .up_data     (up_data),
      .up_idx      (up_idx),
      .up_ready    (up_ready),
      .fwd_count   (fwd_count),
      .busy        (busy)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: apply inputs after negedge, check against the model, then
   // advance the model as if the coming posedge has happened.
   task automatic drive_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
      logic [N-1:0] eg;
      int g;
      bit pop;
      @(negedge clk);
      child_valid = v;
      child_data  = d;
      up_ready    = r;
      #1;
      eg = '0;
      g  = -1;
      if (m_count < D) begin
         for (int k = 0; k < N; k++) begin
            int c = (m_rr + k) % N;
            if (g < 0 && v[c]) g = c;
         end
      end
      if (g >= 0) eg[g] = 1'b1;
      check("child_ready", child_ready, eg);
      check("up_valid", up_valid, m_count != 0);
      check("fwd_count", fwd_count, m_fwd);
      check("busy", busy, (m_count != 0) || (v != 0));
      pop = r && (m_count > 0);
      if (pop) begin
         m_count--;
         if (m_fwd < 65535) m_fwd++;
      end
      if (g >= 0) begin
         sbq.push_back('{g, int'(d[g*W +: W])});
         m_rr = (g + 1) % N;
         tally[g]++;
         m_count++;
      end
      last_g = g;
   endtask

   task automatic rand_cycles(input int n, input int vp, input int rp);
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < N; c++) begin
            if (!cur_v[c] && int'($urandom_range(99)) < vp) begin
               cur_v[c] = 1'b1;
               cur_d[c*W +: W] = W'($urandom);
            end
         end
         drive_cycle(cur_v, cur_d, int'($urandom_range(99)) < rp);
         if (last_g >= 0) cur_v[last_g] = 1'b0;
      end
   endtask

   // Assert rst between edges and check the asynchronous clear immediately.
   task automatic do_reset();
      @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_up_valid", up_valid, 1'b0);
      check("rst_child_ready", child_ready, '0);
      check("rst_fwd_count", fwd_count, 16'h0);
      m_count = 0;
      m_rr    = 0;
      m_fwd   = 0;
      sbq.delete();
      cur_v = '0;
      for (int c = 0; c < N; c++) tally[c] = 0;
      child_valid = '0;
      up_ready    = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (!rst && up_valid && up_ready) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pop_empty: got pop idx %0d expected no pop", up_idx);
            end else begin
               mon_e = sbq.pop_front();
               check("up_idx", up_idx, mon_e.idx);
               check("up_data", up_data, mon_e.data);
               if (!quiet) $display("[TB] pop idx=%0d data=%02h", up_idx, up_data);
            end
         end
      end
   end

   initial begin : stim
      logic [N*W-1:0] dv;
      rst = 1'b1;
      child_valid = '0;
      child_data  = '0;
      up_ready    = 1'b0;
      cur_v = '0;
      cur_d = '0;
      m_count = 0; m_rr = 0; m_fwd = 0; last_g = -1;
      for (int c = 0; c < N; c++) tally[c] = 0;
      #1;
      check("init_up_valid", up_valid, 1'b0);
      check("init_child_ready", child_ready, '0);
      check("init_busy", busy, 1'b0);
      check("init_fwd_count", fwd_count, 16'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single message from child 2.
      dv = '0;
      dv[2*W +: W] = 8'hA5;
      drive_cycle(5'b00100, dv, 1'b1);
      drive_cycle('0, '0, 1'b1);
      drive_cycle('0, '0, 1'b1);

      // Fairness: all children valid, free-flowing upstream.
      do_reset();
      for (int c = 0; c < N; c++) dv[c*W +: W] = W'(8'h10 * (c + 1) + c);
      for (int i = 0; i < 20; i++) drive_cycle('1, dv, 1'b1);
      for (int c = 0; c < N; c++) check($sformatf("tally%0d", c), tally[c], 4);
      for (int i = 0; i < 6; i++) drive_cycle('0, '0, 1'b1);

      // Backpressure until full, single pop, then refill with child 4.
      do_reset();
      for (int i = 0; i < 6; i++) drive_cycle('1, dv, 1'b0);
      drive_cycle('1, dv, 1'b1);
      drive_cycle('1, dv, 1'b0);
      for (int i = 0; i < 6; i++) drive_cycle('0, '0, 1'b1);

      // Simultaneous push and pop with two entries buffered.
      do_reset();
      for (int i = 0; i < 2; i++) begin
         dv[3*W +: W] = W'(8'hC0 + i);
         drive_cycle(5'b01000, dv, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         dv[3*W +: W] = W'(8'hD0 + i);
         drive_cycle(5'b01000, dv, 1'b1);
      end
      for (int i = 0; i < 4; i++) drive_cycle('0, '0, 1'b1);

      // Build count=3, fwd_count=7, then reset mid-stream with child 1 pending.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         dv[1*W +: W] = W'(8'h50 + i);
         drive_cycle(5'b00010, dv, 1'b1);
      end
      for (int i = 0; i < 2; i++) begin
         dv[1*W +: W] = W'(8'h60 + i);
         drive_cycle(5'b00010, dv, 1'b0);
      end
      check("pre_rst_fwd", fwd_count, 16'd7);
      child_valid = 5'b00010;
      do_reset();
      drive_cycle(5'b10110, dv, 1'b1);
      check("post_rst_grant", child_ready, 5'b00010);
      drive_cycle('0, '0, 1'b1);
      drive_cycle('0, '0, 1'b1);

      // Randomized traffic under varying load and backpressure.
      rand_cycles(300, 60, 50);
      rand_cycles(300, 90, 20);
      rand_cycles(300, 30, 90);
      rand_cycles(20, 0, 100);

      // Saturation of the forwarded-message counter.
      quiet = 1'b1;
      do_reset();
      for (int i = 0; i < 65540; i++) drive_cycle('1, dv, 1'b1);
      check("fwd_sat", fwd_count, 16'hFFFF);
      for (int i = 0; i < 6; i++) drive_cycle('0, '0, 1'b1);
      check("fwd_sat_hold", fwd_count, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
